// File: rtl/gp_arbiter.sv
// gp_arbiter: round-robin arbiter in front of the single graphics_processor.
// Grants one latched rectangle command at a time, holds gp_en until
// gp_finish (or the watchdog fires), pulses ack/err, then waits for a
// level-type finish to drop before accepting the next request.
module gp_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 1048575
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     req_opcode_i,
    input  logic [10*N-1:0]  req_tl_x_i,
    input  logic [9*N-1:0]   req_tl_y_i,
    input  logic [10*N-1:0]  req_br_x_i,
    input  logic [9*N-1:0]   req_br_y_i,
    input  logic [12*N-1:0]  req_arg_i,
    input  logic             gp_finish_i,
    output logic             gp_en_o,
    output logic             gp_opcode_o,
    output logic [9:0]       gp_tl_x_o,
    output logic [8:0]       gp_tl_y_o,
    output logic [9:0]       gp_br_x_o,
    output logic [8:0]       gp_br_y_o,
    output logic [11:0]      gp_arg_o,
    output logic [N-1:0]     ack_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [2:0]       grant_id_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

    typedef struct packed {
        logic        op;
        logic [9:0]  tl_x;
        logic [8:0]  tl_y;
        logic [9:0]  br_x;
        logic [8:0]  br_y;
        logic [11:0] arg;
    } cmd_t;

    // Watchdog fires on the last permitted BUSY cycle; TIMEOUT = 0 disables it.
    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [19:0] cnt_q, cnt_d;
    logic        err_flag_q, err_flag_d;
    cmd_t        cmd_q, cmd_d;

    // Rotating priority: shift a doubled request vector so bit 0 is ptr.
    logic [2*N-1:0] req_sh;
    logic [N-1:0]   req_rot;
    logic           found;
    logic [2:0]     sel;
    cmd_t           cmd_sel;

    assign req_sh  = {req_i, req_i} >> ptr_q;
    assign req_rot = req_sh[N-1:0];

    // Pick the first requesting index at or above ptr (with wrap) and its fields.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        cmd_sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                sel   = 3'((int'(ptr_q) + k) % N);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (sel == 3'(i)) begin
                cmd_sel.op   = req_opcode_i[i];
                cmd_sel.tl_x = req_tl_x_i[10*i +: 10];
                cmd_sel.tl_y = req_tl_y_i[9*i +: 9];
                cmd_sel.br_x = req_br_x_i[10*i +: 10];
                cmd_sel.br_y = req_br_y_i[9*i +: 9];
                cmd_sel.arg  = req_arg_i[12*i +: 12];
            end
        end
    end

    // State and command registers; reset clears everything, including mid-command.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            cmd_q      <= cmd_d;
        end
    end

    // Next-state: grant in IDLE, wait for finish/watchdog in BUSY, drain a level finish.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        cmd_d      = cmd_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_BUSY;
                    grant_d = sel;
                    ptr_d   = 3'((int'(sel) + 1) % N);
                    cnt_d   = '0;
                    cmd_d   = cmd_sel;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 20'd1;
                if (gp_finish_i) begin
                    state_d    = S_DONE;
                    err_flag_d = 1'b0;
                end else if (WD_EN && (cnt_q == TO_LAST)) begin
                    state_d    = S_DONE;
                    err_flag_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!gp_finish_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        gp_en_o = (state_q == S_BUSY);
        busy_o  = (state_q != S_IDLE);
        err_o   = (state_q == S_DONE) && err_flag_q;
        ack_o   = '0;
        for (int i = 0; i < N; i++) begin
            ack_o[i] = (state_q == S_DONE) && (grant_q == 3'(i));
        end
    end

    assign gp_opcode_o = cmd_q.op;
    assign gp_tl_x_o   = cmd_q.tl_x;
    assign gp_tl_y_o   = cmd_q.tl_y;
    assign gp_br_x_o   = cmd_q.br_x;
    assign gp_br_y_o   = cmd_q.br_y;
    assign gp_arg_o    = cmd_q.arg;
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_gp_arbiter.sv
// tb_gp_arbiter: scoreboard bench for gp_arbiter (N = 2 with a short
// watchdog, plus an N = 4 instance for the sparse round-robin pattern).
module tb_gp_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N = 2 instance signals
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_op;
    logic [19:0] tlx;
    logic [17:0] tly;
    logic [19:0] brx;
    logic [17:0] bry;
    logic [23:0] arg;
    logic        fin;
    logic        gp_en, gp_opcode, err, busy;
    logic [9:0]  gp_tl_x, gp_br_x;
    logic [8:0]  gp_tl_y, gp_br_y;
    logic [11:0] gp_arg;
    logic [1:0]  ack;
    logic [2:0]  grant_id;

    gp_arbiter #(.N(2), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_opcode_i(req_op),
        .req_tl_x_i(tlx), .req_tl_y_i(tly), .req_br_x_i(brx), .req_br_y_i(bry),
        .req_arg_i(arg), .gp_finish_i(fin), .gp_en_o(gp_en), .gp_opcode_o(gp_opcode),
        .gp_tl_x_o(gp_tl_x), .gp_tl_y_o(gp_tl_y), .gp_br_x_o(gp_br_x), .gp_br_y_o(gp_br_y),
        .gp_arg_o(gp_arg), .ack_o(ack), .err_o(err), .busy_o(busy), .grant_id_o(grant_id)
    );

    // N = 4 instance signals
    logic [3:0]  req4;
    logic        fin4;
    logic        gp_en4, gp_opcode4, err4, busy4;
    logic [9:0]  gp_tl_x4, gp_br_x4;
    logic [8:0]  gp_tl_y4, gp_br_y4;
    logic [11:0] gp_arg4;
    logic [3:0]  ack4;
    logic [2:0]  grant_id4;

    gp_arbiter #(.N(4), .TIMEOUT(0)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req4), .req_opcode_i(4'b0),
        .req_tl_x_i(40'b0), .req_tl_y_i(36'b0), .req_br_x_i(40'b0), .req_br_y_i(36'b0),
        .req_arg_i(48'b0), .gp_finish_i(fin4), .gp_en_o(gp_en4), .gp_opcode_o(gp_opcode4),
        .gp_tl_x_o(gp_tl_x4), .gp_tl_y_o(gp_tl_y4), .gp_br_x_o(gp_br_x4), .gp_br_y_o(gp_br_y4),
        .gp_arg_o(gp_arg4), .ack_o(ack4), .err_o(err4), .busy_o(busy4), .grant_id_o(grant_id4)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bench-side copy of each requester's command
    logic        t_op  [2];
    logic [9:0]  t_tlx [2];
    logic [8:0]  t_tly [2];
    logic [9:0]  t_brx [2];
    logic [8:0]  t_bry [2];
    logic [11:0] t_arg [2];

    typedef struct {
        int          id;
        logic        op;
        logic [9:0]  tlx;
        logic [8:0]  tly;
        logic [9:0]  brx;
        logic [8:0]  bry;
        logic [11:0] arg;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int id, input logic op, input logic [9:0] x0, input logic [8:0] y0,
                           input logic [9:0] x1, input logic [8:0] y1, input logic [11:0] a);
        t_op[id] = op;  t_tlx[id] = x0; t_tly[id] = y0;
        t_brx[id] = x1; t_bry[id] = y1; t_arg[id] = a;
        req_op = {t_op[1], t_op[0]};
        tlx = {t_tlx[1], t_tlx[0]};
        tly = {t_tly[1], t_tly[0]};
        brx = {t_brx[1], t_brx[0]};
        bry = {t_bry[1], t_bry[0]};
        arg = {t_arg[1], t_arg[0]};
    endtask

    task automatic push_exp(input int id, input logic e);
        exp_t x;
        x.id = id;  x.op = t_op[id];   x.tlx = t_tlx[id]; x.tly = t_tly[id];
        x.brx = t_brx[id]; x.bry = t_bry[id]; x.arg = t_arg[id]; x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_grant(input int budget, output int lat);
        lat = 0;
        while (gp_en !== 1'b1 && lat < budget) begin
            tick();
            lat++;
        end
        chk("grant_seen", gp_en, 1);
        if (sb.size() == 0) begin
            chk("sb_has_entry_at_grant", 0, 1);
        end else begin
            chk("grant_id", grant_id, sb[0].id);
            chk("gp_opcode", gp_opcode, sb[0].op);
            chk("gp_tl_x", gp_tl_x, sb[0].tlx);
            chk("gp_tl_y", gp_tl_y, sb[0].tly);
            chk("gp_br_x", gp_br_x, sb[0].brx);
            chk("gp_br_y", gp_br_y, sb[0].bry);
            chk("gp_arg", gp_arg, sb[0].arg);
        end
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (ack === 2'b00 && n < budget) begin
            tick();
            n++;
        end
        chk("ack_seen", |ack, 1);
        if (sb.size() == 0) begin
            chk("sb_has_entry_at_ack", 0, 1);
        end else begin
            chk("ack_vec", ack, 1 << sb[0].id);
            chk("err_at_ack", err, sb[0].err);
            chk("gp_en_low_at_ack", gp_en, 0);
            void'(sb.pop_front());
        end
        tick();
        chk("ack_one_cycle", ack, 0);
        chk("err_one_cycle", err, 0);
    endtask

    task automatic pulse_finish();
        fin = 1'b1;
        tick();
        fin = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        int lat;
        int hi;
        int n;
        int id;
        int exp_id;

        rst_n = 1'b0;
        req = 2'b11;
        fin = 1'b0;
        req4 = 4'b0;
        fin4 = 1'b0;
        set_cmd(0, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h000);
        set_cmd(1, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h000);

        // Reset held with both requests high
        repeat (3) tick();
        chk("rst_gp_en", gp_en, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err", err, 0);
        chk("rst_gp_arg", gp_arg, 0);
        req = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single request on requester 1, arg altered during BUSY
        set_cmd(1, 1'b1, 10'd10, 9'd20, 10'd100, 9'd50, 12'hF00);
        push_exp(1, 1'b0);
        req = 2'b10;
        wait_grant(4, lat);
        chk("single_latency", lat, 1);
        chk("single_busy", busy, 1);
        arg[23:12] = 12'h0AB;
        repeat (4) tick();
        chk("single_en_held", gp_en, 1);
        chk("stable_arg", gp_arg, 12'hF00);
        pulse_finish();
        wait_ack(2);
        req = 2'b00;

        // Level finish: one ack, requester 1 raised during BUSY waits for IDLE
        set_cmd(0, 1'b0, 10'd1, 9'd2, 10'd3, 9'd4, 12'h123);
        set_cmd(1, 1'b1, 10'd300, 9'd200, 10'd639, 9'd479, 12'hABC);
        push_exp(0, 1'b0);
        push_exp(1, 1'b0);
        req = 2'b01;
        wait_grant(4, lat);
        req[1] = 1'b1;
        tick();
        tick();
        chk("busy_ignores_req", grant_id, 0);
        fin = 1'b1;
        wait_ack(3);
        req[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("level_no_ack", ack, 0);
            chk("level_no_grant", gp_en, 0);
            tick();
        end
        chk("level_busy_drain", busy, 1);
        fin = 1'b0;
        wait_grant(6, lat);
        chk("level_regrant_latency", lat, 2);
        pulse_finish();
        wait_ack(2);
        req = 2'b00;

        // Round-robin with both requesters active
        set_cmd(0, 1'b1, 10'd5, 9'd6, 10'd7, 9'd8, 12'h055);
        set_cmd(1, 1'b0, 10'd50, 9'd60, 10'd70, 9'd80, 12'h0AA);
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            id = r % 2;
            push_exp(id, 1'b0);
            wait_grant(6, lat);
            tick();
            pulse_finish();
            wait_ack(2);
            req[id] = 1'b0;
            tick();
            req[id] = 1'b1;
        end
        req = 2'b00;
        repeat (3) tick();

        // Watchdog: finish never arrives
        set_cmd(0, 1'b0, 10'd11, 9'd12, 10'd13, 9'd14, 12'hDEA);
        push_exp(0, 1'b1);
        req = 2'b01;
        wait_grant(4, lat);
        hi = 1;
        while (hi < 40) begin
            tick();
            if (gp_en === 1'b1) hi++;
            else break;
        end
        chk("wd_en_cycles", hi, 16);
        wait_ack(2);
        req = 2'b00;

        // Finish coincident with the watchdog's last cycle: no error
        set_cmd(1, 1'b1, 10'd21, 9'd22, 10'd23, 9'd24, 12'hBEE);
        push_exp(1, 1'b0);
        req = 2'b10;
        wait_grant(4, lat);
        repeat (15) tick();
        chk("coinc_en_still", gp_en, 1);
        pulse_finish();
        wait_ack(2);
        req = 2'b00;
        tick();

        // Reset mid-BUSY after a grant to requester 0 (which moves ptr to 1)
        set_cmd(0, 1'b1, 10'd31, 9'd32, 10'd33, 9'd34, 12'h777);
        push_exp(0, 1'b0);
        req = 2'b01;
        wait_grant(4, lat);
        tick();
        rst_n = 1'b0;
        req = 2'b00;
        tick();
        chk("midrst_gp_en", gp_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_gp_tl_x", gp_tl_x, 0);
        chk("midrst_ack", ack, 0);
        sb.delete();
        rst_n = 1'b1;
        tick();
        // ptr must be back at 0: requester 0 wins over 1
        push_exp(0, 1'b0);
        req = 2'b11;
        wait_grant(4, lat);
        pulse_finish();
        wait_ack(2);
        req = 2'b00;
        repeat (2) tick();

        // N = 4, requesters 1 and 3 held: grants alternate 1, 3
        req4 = 4'b1010;
        for (int r = 0; r < 4; r++) begin
            exp_id = (r % 2 == 0) ? 1 : 3;
            n = 0;
            while (gp_en4 !== 1'b1 && n < 6) begin
                tick();
                n++;
            end
            chk("n4_grant_seen", gp_en4, 1);
            chk("n4_grant_id", grant_id4, exp_id);
            fin4 = 1'b1;
            tick();
            fin4 = 1'b0;
            chk("n4_ack", ack4, 1 << exp_id);
            chk("n4_err", err4, 0);
            tick();
        end
        req4 = 4'b0;

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/gp_arbiter.md
# gp_arbiter

Arbitrates the single graphics_processor between up to N drawing requesters, e.g. game_controller plus a score/octave overlay painter. Each requester presents a latched rectangle command with a req/ack handshake; the arbiter grants round-robin, drives gp_en and the command fields, and waits for gp_finish. A watchdog aborts commands that never finish. Sits between the requesters and graphics_processor in cyber_melody.

## Interface
- N, 2: number of requesters (2..8).
- TIMEOUT, 1048575: max cycles in BUSY before abort; 0 disables the watchdog.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N  request per requester; level, held until ack.
- req_opcode  in  N  opcode of requester i at bit i.
- req_tl_x  in  10*N  tl_x of requester i at bits [10i+9:10i]; same packing for the next four ports.
- req_tl_y  in  9*N  top-left y.
- req_br_x  in  10*N  bottom-right x.
- req_br_y  in  9*N  bottom-right y.
- req_arg  in  12*N  colour or ROM base argument.
- gp_finish  in  1  graphics_processor done (level or pulse).
- gp_en  out  1  command valid to graphics_processor.
- gp_opcode, gp_tl_x[9:0], gp_tl_y[8:0], gp_br_x[9:0], gp_br_y[8:0], gp_arg[11:0]  out  registered command fields.
- ack  out  N  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse, coincident with ack, when the command timed out.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.

## Operation
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE: when any req bit is high, select the first set bit searching upward from the priority pointer ptr with wrap. Latch that requester's fields into the gp_* registers and set grant_id. Set ptr = (grant+1) mod N. Go to BUSY.
- BUSY: gp_en = 1, fields stable. The watchdog counter increments each cycle.
  - gp_finish = 1: go to DONE, err_flag = 0.
  - TIMEOUT != 0 and counter == TIMEOUT-1 with gp_finish = 0: go to DONE, err_flag = 1.
  - gp_finish wins if both occur in the same cycle.
- DONE (one cycle): gp_en = 0, ack[grant_id] = 1, err = err_flag. Go to DRAIN.
- DRAIN: wait until gp_finish = 0, then go to IDLE. A level-type finish is therefore never re-read as completion of the next command.
- req bits are ignored outside IDLE. Requesters must drop req in the cycle after they see ack, otherwise they are granted again.
- A req that falls before grant is simply not granted.
- Once latched, a command completes or times out regardless of its req.
- Changes to req_* fields after grant have no effect.
- Watchdog counter is 20 bits and clears on entry to BUSY.
- Reset, including mid-command: state IDLE, ptr = 0, counter = 0. All outputs are 0: gp_en, gp_* fields, ack, err, busy, grant_id. Reset wins over every other event.

## Timing
- req sampled high at edge t in IDLE: gp_en and fields valid from t+1, busy = 1 from t+1.
- gp_finish sampled high at edge f in BUSY: gp_en = 0 and ack/err pulse during cycle f+1.
- DRAIN lasts 0 extra cycles if finish is already low at edge f+1, otherwise until it falls.
- Earliest next grant: the edge after returning to IDLE. Minimum cycle per command: 4 edges with a one-cycle pulse finish.
- Timeout: gp_en is high for exactly TIMEOUT cycles, then ack+err.
- All outputs are registered; no combinational path from req or gp_finish to any output.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with req = 2'b11 -> gp_en = 0, ack = 0, busy = 0, grant_id = 0. Assert rst_n = 0 mid-BUSY -> gp_en = 0 on the next edge.
- Single request: req[1] with tl = (10, 20), br = (100, 50), arg = 12'hF00; finish pulses 5 cycles after gp_en -> fields match, ack = 2'b10 for one cycle, err = 0.
- Round-robin: req = 2'b11 held, each requester drops req on its ack and re-raises 2 cycles later -> grants alternate 0, 1, 0, 1. With N = 4 and req = 4'b1010, grants alternate 1, 3.
- Level finish: gp_finish stays high for 6 cycles after completion -> exactly one ack, and no second grant until finish is low.
- Watchdog: TIMEOUT = 16, gp_finish tied 0 -> gp_en high for exactly 16 cycles, then ack with err = 1. Finish and timeout in the same cycle -> err = 0.
- Stability: change req_arg of the granted requester during BUSY -> gp_arg unchanged. req outside IDLE is not granted until IDLE.
